// File: rtl/pkt_latency_monitor.sv
// Packet latency monitor: timestamps the first rx beat of each packet and pairs
// it with the next tx last beat, producing {rx, tx, delta} records in a FIFO.
module pkt_latency_monitor #(
  parameter int CNT_WIDTH  = 32,
  parameter int DEPTH      = 8,
  parameter int DROP_WIDTH = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  rx_tvalid_i,
  input  logic                  rx_tready_i,
  input  logic                  rx_tlast_i,
  input  logic                  tx_tvalid_i,
  input  logic                  tx_tready_i,
  input  logic                  tx_tlast_i,
  input  logic                  clear_i,
  output logic                  rec_valid_o,
  input  logic                  rec_ready_i,
  output logic [CNT_WIDTH-1:0]  rec_rx_ticks_o,
  output logic [CNT_WIDTH-1:0]  rec_tx_ticks_o,
  output logic [CNT_WIDTH-1:0]  rec_delta_o,
  output logic                  rec_orphan_o,
  output logic [CNT_WIDTH-1:0]  max_delta_o,
  output logic [DROP_WIDTH-1:0] rx_drop_cnt_o,
  output logic [DROP_WIDTH-1:0] rec_drop_cnt_o
);

  localparam int AW = $clog2(DEPTH);

  typedef logic [CNT_WIDTH-1:0]  cnt_t;
  typedef logic [AW:0]           ptr_t;
  typedef logic [DROP_WIDTH-1:0] drop_t;

  typedef struct packed {
    cnt_t rx;
    cnt_t tx;
    cnt_t delta;
    logic orphan;
  } rec_t;

  localparam cnt_t  CNT_ONE  = cnt_t'(1);
  localparam ptr_t  PTR_ONE  = ptr_t'(1);
  localparam drop_t DROP_ONE = drop_t'(1);

  cnt_t  r_tick;
  logic  r_first;
  cnt_t  r_stamp_mem [DEPTH];
  ptr_t  r_stamp_wr;
  ptr_t  r_stamp_rd;
  rec_t  r_rec_mem [DEPTH];
  ptr_t  r_rec_wr;
  ptr_t  r_rec_rd;
  cnt_t  r_max_delta;
  drop_t r_rx_drop;
  drop_t r_rec_drop;

  logic  w_rx_hs;
  logic  w_rx_first;
  logic  w_tx_done;
  logic  w_stamp_empty;
  logic  w_stamp_full;
  logic  w_stamp_pop;
  logic  w_stamp_push;
  logic  w_rx_drop;
  cnt_t  w_stamp_head;
  cnt_t  w_delta;
  rec_t  w_new_rec;
  logic  w_rec_empty;
  logic  w_rec_full;
  logic  w_rec_pop;
  logic  w_rec_push;
  logic  w_rec_drop;
  rec_t  w_rec_head;

  // Events are suppressed while clear_i is high so a flush discards them.
  assign w_rx_hs    = rx_tvalid_i & rx_tready_i;
  assign w_rx_first = w_rx_hs & r_first & ~clear_i;
  assign w_tx_done  = tx_tvalid_i & tx_tready_i & tx_tlast_i & ~clear_i;

  assign w_stamp_empty = (r_stamp_wr == r_stamp_rd);
  assign w_stamp_full  = (r_stamp_wr[AW] != r_stamp_rd[AW]) &&
                         (r_stamp_wr[AW-1:0] == r_stamp_rd[AW-1:0]);
  assign w_stamp_pop   = w_tx_done & ~w_stamp_empty;
  assign w_stamp_push  = w_rx_first & (~w_stamp_full | w_stamp_pop);
  assign w_rx_drop     = w_rx_first & w_stamp_full & ~w_stamp_pop;
  assign w_stamp_head  = r_stamp_mem[r_stamp_rd[AW-1:0]];
  assign w_delta       = r_tick - w_stamp_head;

  // NOTE: every field gets a default before the branch, so no latch is inferred.
  always_comb begin
    w_new_rec.rx     = '0;
    w_new_rec.tx     = r_tick;
    w_new_rec.delta  = '0;
    w_new_rec.orphan = 1'b1;
    if (w_stamp_pop) begin
      w_new_rec.rx     = w_stamp_head;
      w_new_rec.delta  = w_delta;
      w_new_rec.orphan = 1'b0;
    end
  end

  assign w_rec_empty = (r_rec_wr == r_rec_rd);
  assign w_rec_full  = (r_rec_wr[AW] != r_rec_rd[AW]) &&
                       (r_rec_wr[AW-1:0] == r_rec_rd[AW-1:0]);
  assign w_rec_pop   = ~w_rec_empty & rec_ready_i & ~clear_i;
  assign w_rec_push  = w_tx_done & (~w_rec_full | w_rec_pop);
  assign w_rec_drop  = w_tx_done & w_rec_full & ~w_rec_pop;
  assign w_rec_head  = r_rec_mem[r_rec_rd[AW-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_tick <= '0;
    end else begin
      r_tick <= r_tick + CNT_ONE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_first <= 1'b1;
    end else if (clear_i) begin
      r_first <= 1'b1;
    end else if (w_rx_hs) begin
      r_first <= rx_tlast_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_stamp_wr <= '0;
      r_stamp_rd <= '0;
      r_rec_wr   <= '0;
      r_rec_rd   <= '0;
    end else if (clear_i) begin
      r_stamp_wr <= '0;
      r_stamp_rd <= '0;
      r_rec_wr   <= '0;
      r_rec_rd   <= '0;
    end else begin
      if (w_stamp_push) r_stamp_wr <= r_stamp_wr + PTR_ONE;
      if (w_stamp_pop)  r_stamp_rd <= r_stamp_rd + PTR_ONE;
      if (w_rec_push)   r_rec_wr   <= r_rec_wr + PTR_ONE;
      if (w_rec_pop)    r_rec_rd   <= r_rec_rd + PTR_ONE;
    end
  end

  // NOTE: storage arrays are not reset; the pointers alone define validity and
  // the outputs are masked while the record FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (w_stamp_push) r_stamp_mem[r_stamp_wr[AW-1:0]] <= r_tick;
    if (w_rec_push)   r_rec_mem[r_rec_wr[AW-1:0]]     <= w_new_rec;
  end

  // Max tracks every paired record, including those lost at a full record FIFO.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_max_delta <= '0;
      r_rx_drop   <= '0;
      r_rec_drop  <= '0;
    end else if (clear_i) begin
      r_max_delta <= '0;
      r_rx_drop   <= '0;
      r_rec_drop  <= '0;
    end else begin
      if (w_stamp_pop && (w_delta > r_max_delta)) r_max_delta <= w_delta;
      if (w_rx_drop && (r_rx_drop != '1))         r_rx_drop   <= r_rx_drop + DROP_ONE;
      if (w_rec_drop && (r_rec_drop != '1))       r_rec_drop  <= r_rec_drop + DROP_ONE;
    end
  end

  assign rec_valid_o    = ~w_rec_empty;
  assign rec_rx_ticks_o = w_rec_empty ? '0 : w_rec_head.rx;
  assign rec_tx_ticks_o = w_rec_empty ? '0 : w_rec_head.tx;
  assign rec_delta_o    = w_rec_empty ? '0 : w_rec_head.delta;
  assign rec_orphan_o   = w_rec_empty ? 1'b0 : w_rec_head.orphan;
  assign max_delta_o    = r_max_delta;
  assign rx_drop_cnt_o  = r_rx_drop;
  assign rec_drop_cnt_o = r_rec_drop;

endmodule

// File: tb/tb_pkt_latency_monitor.sv
// Self-checking bench for pkt_latency_monitor: directed scenarios plus random
// traffic compared against a queue-based reference model.
module tb_pkt_latency_monitor;

  localparam int CW = 8;
  localparam int DP = 4;
  localparam int DW = 3;
  localparam int DROP_MAX = 7;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          rx_tvalid_i, rx_tready_i, rx_tlast_i;
  logic          tx_tvalid_i, tx_tready_i, tx_tlast_i;
  logic          clear_i, rec_ready_i;
  logic          rec_valid_o, rec_orphan_o;
  logic [CW-1:0] rec_rx_ticks_o, rec_tx_ticks_o, rec_delta_o, max_delta_o;
  logic [DW-1:0] rx_drop_cnt_o, rec_drop_cnt_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_i = ~clk_i;

  pkt_latency_monitor #(.CNT_WIDTH(CW), .DEPTH(DP), .DROP_WIDTH(DW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .rx_tvalid_i(rx_tvalid_i), .rx_tready_i(rx_tready_i), .rx_tlast_i(rx_tlast_i),
    .tx_tvalid_i(tx_tvalid_i), .tx_tready_i(tx_tready_i), .tx_tlast_i(tx_tlast_i),
    .clear_i(clear_i), .rec_valid_o(rec_valid_o), .rec_ready_i(rec_ready_i),
    .rec_rx_ticks_o(rec_rx_ticks_o), .rec_tx_ticks_o(rec_tx_ticks_o),
    .rec_delta_o(rec_delta_o), .rec_orphan_o(rec_orphan_o),
    .max_delta_o(max_delta_o), .rx_drop_cnt_o(rx_drop_cnt_o),
    .rec_drop_cnt_o(rec_drop_cnt_o)
  );

  // Reference model: queues of stamps and records, stepped once per rising edge.
  typedef struct packed {
    logic [CW-1:0] rx;
    logic [CW-1:0] tx;
    logic [CW-1:0] delta;
    logic          orphan;
  } mrec_t;

  logic [CW-1:0] m_tick;
  logic [CW-1:0] m_stamps[$];
  mrec_t         m_recs[$];
  bit            m_first;
  logic [CW-1:0] m_max;
  int            m_rxd, m_recd;

  task automatic model_reset();
    m_tick = '0; m_stamps.delete(); m_recs.delete();
    m_first = 1'b1; m_max = '0; m_rxd = 0; m_recd = 0;
  endtask

  task automatic model_step();
    bit    rx_hs, tx_done, rec_pop;
    mrec_t r;
    if (!rst_ni) return;
    if (clear_i) begin
      m_stamps.delete(); m_recs.delete();
      m_first = 1'b1; m_max = '0; m_rxd = 0; m_recd = 0;
    end else begin
      rx_hs   = rx_tvalid_i && rx_tready_i;
      tx_done = tx_tvalid_i && tx_tready_i && tx_tlast_i;
      rec_pop = (m_recs.size() != 0) && rec_ready_i;
      r = '0;
      if (tx_done) begin
        r.tx = m_tick;
        if (m_stamps.size() != 0) begin
          r.rx = m_stamps.pop_front();
          r.delta = m_tick - r.rx;
          if (r.delta > m_max) m_max = r.delta;
        end else begin
          r.orphan = 1'b1;
        end
      end
      if (rec_pop) m_recs.delete(0);
      if (tx_done) begin
        if (m_recs.size() < DP) m_recs.push_back(r);
        else if (m_recd < DROP_MAX) m_recd++;
      end
      if (rx_hs && m_first) begin
        if (m_stamps.size() < DP) m_stamps.push_back(m_tick);
        else if (m_rxd < DROP_MAX) m_rxd++;
      end
      if (rx_hs) m_first = rx_tlast_i;
    end
    m_tick = m_tick + 8'd1;
  endtask

  task automatic cycle();
    @(posedge clk_i);
    model_step();
    @(negedge clk_i);
  endtask

  task automatic pulse(input bit rxv, input bit rxl, input bit txv, input bit txl);
    rx_tvalid_i = rxv; rx_tready_i = rxv; rx_tlast_i = rxl;
    tx_tvalid_i = txv; tx_tready_i = txv; tx_tlast_i = txl;
    cycle();
    rx_tvalid_i = 0; rx_tready_i = 0; rx_tlast_i = 0;
    tx_tvalid_i = 0; tx_tready_i = 0; tx_tlast_i = 0;
  endtask

  task automatic wait_tick(input logic [CW-1:0] t);
    int n = 0;
    while (m_tick != t && n < 600) begin cycle(); n++; end
    if (m_tick != t) begin
      n_checks++; n_errors++;
      $display("FAIL wait_tick timeout: at %0d, wanted %0d", m_tick, t);
    end
  endtask

  task automatic do_reset();
    rst_ni = 1'b0; model_reset();
    rx_tvalid_i = 0; rx_tready_i = 0; rx_tlast_i = 0;
    tx_tvalid_i = 0; tx_tready_i = 0; tx_tlast_i = 0;
    clear_i = 0; rec_ready_i = 0;
    @(negedge clk_i);
    repeat (2) cycle();
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    repeat (3) cycle();
    n_checks++; if (rec_valid_o !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b exp 0", rec_valid_o); end
    n_checks++; if (rec_rx_ticks_o !== 8'd0 || rec_tx_ticks_o !== 8'd0 || rec_delta_o !== 8'd0 || rec_orphan_o !== 1'b0) begin
      n_errors++; $display("FAIL reset_fields: got %0d/%0d/%0d/%b exp 0", rec_rx_ticks_o, rec_tx_ticks_o, rec_delta_o, rec_orphan_o); end
    n_checks++; if (max_delta_o !== 8'd0 || rx_drop_cnt_o !== 3'd0 || rec_drop_cnt_o !== 3'd0) begin
      n_errors++; $display("FAIL reset_stats: got %0d/%0d/%0d exp 0", max_delta_o, rx_drop_cnt_o, rec_drop_cnt_o); end
  endtask

  task automatic test_single_packet();
    do_reset();
    wait_tick(8'd10);
    pulse(1, 0, 0, 0); pulse(1, 0, 0, 0); pulse(1, 1, 0, 0);
    wait_tick(8'd48);
    pulse(0, 0, 1, 0); pulse(0, 0, 1, 0); pulse(0, 0, 1, 1);
    n_checks++; if (rec_valid_o !== 1'b1) begin n_errors++; $display("FAIL single_valid: got %b exp 1", rec_valid_o); end
    n_checks++; if (rec_rx_ticks_o !== 8'd10) begin n_errors++; $display("FAIL single_rx: got %0d exp 10", rec_rx_ticks_o); end
    n_checks++; if (rec_tx_ticks_o !== 8'd50) begin n_errors++; $display("FAIL single_tx: got %0d exp 50", rec_tx_ticks_o); end
    n_checks++; if (rec_delta_o !== 8'd40 || rec_orphan_o !== 1'b0) begin
      n_errors++; $display("FAIL single_delta: got %0d orphan %b exp 40 orphan 0", rec_delta_o, rec_orphan_o); end
    n_checks++; if (max_delta_o !== 8'd40) begin n_errors++; $display("FAIL single_max: got %0d exp 40", max_delta_o); end
    rec_ready_i = 1; cycle(); rec_ready_i = 0;
    n_checks++; if (rec_valid_o !== 1'b0) begin n_errors++; $display("FAIL single_pop: valid %b exp 0", rec_valid_o); end
  endtask

  task automatic test_wrap();
    do_reset();
    wait_tick(8'd250);
    pulse(1, 1, 0, 0);
    wait_tick(8'd4);
    pulse(0, 0, 1, 1);
    n_checks++; if (rec_rx_ticks_o !== 8'd250 || rec_tx_ticks_o !== 8'd4) begin
      n_errors++; $display("FAIL wrap_ticks: got rx %0d tx %0d exp 250/4", rec_rx_ticks_o, rec_tx_ticks_o); end
    n_checks++; if (rec_delta_o !== 8'd10) begin n_errors++; $display("FAIL wrap_delta: got %0d exp 10", rec_delta_o); end
    n_checks++; if (max_delta_o !== 8'd10) begin n_errors++; $display("FAIL wrap_max: got %0d exp 10", max_delta_o); end
  endtask

  task automatic test_overflow();
    logic [CW-1:0] exp_rx[6];
    do_reset();
    for (int i = 0; i < 6; i++) begin exp_rx[i] = m_tick; pulse(1, 1, 0, 0); pulse(0, 0, 0, 0); end
    n_checks++; if (rx_drop_cnt_o !== 3'd2) begin n_errors++; $display("FAIL ovf_rx_drop: got %0d exp 2", rx_drop_cnt_o); end
    rec_ready_i = 1;
    for (int i = 0; i < 5; i++) begin
      pulse(0, 0, 1, 1);
      n_checks++; if (rec_valid_o !== 1'b1 || rec_orphan_o !== (i == 4)) begin
        n_errors++; $display("FAIL ovf_rec%0d: valid %b orphan %b exp 1/%b", i, rec_valid_o, rec_orphan_o, i == 4); end
      if (i < 4) begin
        n_checks++; if (rec_rx_ticks_o !== exp_rx[i]) begin n_errors++; $display("FAIL ovf_rx%0d: got %0d exp %0d", i, rec_rx_ticks_o, exp_rx[i]); end
      end
    end
    cycle(); rec_ready_i = 0;
    n_checks++; if (rec_valid_o !== 1'b0 || rec_drop_cnt_o !== 3'd0) begin
      n_errors++; $display("FAIL ovf_end: valid %b rec_drop %0d exp 0/0", rec_valid_o, rec_drop_cnt_o); end
  endtask

  task automatic test_back_pressure();
    logic [CW-1:0] exp_rx[DP], exp_tx[DP];
    do_reset();
    for (int i = 0; i < DP; i++) begin exp_rx[i] = m_tick; pulse(1, 1, 0, 0); end
    for (int i = 0; i < DP + 2; i++) begin
      if (i < DP) exp_tx[i] = m_tick;
      pulse(0, 0, 1, 1);
      n_checks++; if (rec_rx_ticks_o !== exp_rx[0] || rec_tx_ticks_o !== exp_tx[0]) begin
        n_errors++; $display("FAIL bp_stable%0d: got %0d/%0d exp %0d/%0d", i, rec_rx_ticks_o, rec_tx_ticks_o, exp_rx[0], exp_tx[0]); end
    end
    n_checks++; if (rec_drop_cnt_o !== 3'd2 || rx_drop_cnt_o !== 3'd0) begin
      n_errors++; $display("FAIL bp_drops: rec %0d rx %0d exp 2/0", rec_drop_cnt_o, rx_drop_cnt_o); end
    rec_ready_i = 1;
    for (int i = 0; i < DP; i++) begin
      n_checks++; if (rec_valid_o !== 1'b1 || rec_orphan_o !== 1'b0 || rec_rx_ticks_o !== exp_rx[i] ||
                      rec_tx_ticks_o !== exp_tx[i] || rec_delta_o !== 8'(exp_tx[i] - exp_rx[i])) begin
        n_errors++; $display("FAIL bp_order%0d: got v%b o%b %0d/%0d/%0d exp %0d/%0d", i, rec_valid_o, rec_orphan_o,
                             rec_rx_ticks_o, rec_tx_ticks_o, rec_delta_o, exp_rx[i], exp_tx[i]); end
      cycle();
    end
    rec_ready_i = 0;
    n_checks++; if (rec_valid_o !== 1'b0) begin n_errors++; $display("FAIL bp_empty: valid %b exp 0", rec_valid_o); end
  endtask

  task automatic test_simultaneous();
    logic [CW-1:0] t0, t1;
    do_reset();
    repeat (5) cycle();
    t0 = m_tick;
    pulse(1, 1, 1, 1);
    n_checks++; if (rec_valid_o !== 1'b1 || rec_orphan_o !== 1'b1 || rec_tx_ticks_o !== t0 || rec_rx_ticks_o !== 8'd0) begin
      n_errors++; $display("FAIL simul_orphan: v%b o%b rx %0d tx %0d exp 1/1/0/%0d", rec_valid_o, rec_orphan_o, rec_rx_ticks_o, rec_tx_ticks_o, t0); end
    rec_ready_i = 1; cycle(); rec_ready_i = 0;
    repeat (3) cycle();
    t1 = m_tick;
    pulse(0, 0, 1, 1);
    n_checks++; if (rec_orphan_o !== 1'b0 || rec_rx_ticks_o !== t0 || rec_delta_o !== 8'(t1 - t0)) begin
      n_errors++; $display("FAIL simul_pair: o%b rx %0d delta %0d exp 0/%0d/%0d", rec_orphan_o, rec_rx_ticks_o, rec_delta_o, t0, 8'(t1 - t0)); end
  endtask

  task automatic test_clear();
    logic [CW-1:0] exp_rx[5], exp_tx[3], t2;
    logic [CW-1:0] exp_max;
    do_reset();
    for (int i = 0; i < 5; i++) begin exp_rx[i] = m_tick; pulse(1, 1, 0, 0); pulse(0, 0, 0, 0); end
    for (int i = 0; i < 3; i++) begin exp_tx[i] = m_tick; pulse(0, 0, 1, 1); end
    pulse(1, 0, 0, 0);
    exp_max = 0;
    for (int i = 0; i < 3; i++) if (8'(exp_tx[i] - exp_rx[i]) > exp_max) exp_max = 8'(exp_tx[i] - exp_rx[i]);
    n_checks++; if (rec_valid_o !== 1'b1 || rx_drop_cnt_o !== 3'd1 || max_delta_o !== exp_max) begin
      n_errors++; $display("FAIL clr_pre: v%b rxd %0d max %0d exp 1/1/%0d", rec_valid_o, rx_drop_cnt_o, max_delta_o, exp_max); end
    clear_i = 1;
    rx_tvalid_i = 1; rx_tready_i = 1; tx_tvalid_i = 1; tx_tready_i = 1; tx_tlast_i = 1;
    cycle();
    clear_i = 0;
    rx_tvalid_i = 0; rx_tready_i = 0; tx_tvalid_i = 0; tx_tready_i = 0; tx_tlast_i = 0;
    n_checks++; if (rec_valid_o !== 1'b0) begin n_errors++; $display("FAIL clr_valid: got %b exp 0", rec_valid_o); end
    n_checks++; if (max_delta_o !== 8'd0 || rx_drop_cnt_o !== 3'd0 || rec_drop_cnt_o !== 3'd0) begin
      n_errors++; $display("FAIL clr_stats: got %0d/%0d/%0d exp 0", max_delta_o, rx_drop_cnt_o, rec_drop_cnt_o); end
    t2 = m_tick;
    pulse(1, 0, 0, 0);
    pulse(0, 0, 1, 1);
    n_checks++; if (rec_valid_o !== 1'b1 || rec_orphan_o !== 1'b0 || rec_rx_ticks_o !== t2) begin
      n_errors++; $display("FAIL clr_first: v%b o%b rx %0d exp 1/0/%0d", rec_valid_o, rec_orphan_o, rec_rx_ticks_o, t2); end
  endtask

  task automatic test_reset_midpacket();
    logic [CW-1:0] t3;
    do_reset();
    for (int i = 0; i < 5; i++) pulse(1, 1, 0, 0);
    pulse(1, 0, 0, 0);
    repeat (4) cycle();
    pulse(0, 0, 1, 1);
    #2 rst_ni = 1'b0; model_reset();
    #1;
    n_checks++; if (rec_valid_o !== 1'b0 || rec_rx_ticks_o !== 8'd0 || rec_tx_ticks_o !== 8'd0 ||
                    rec_delta_o !== 8'd0 || rec_orphan_o !== 1'b0) begin
      n_errors++; $display("FAIL rst_async_rec: v%b %0d/%0d/%0d o%b exp 0", rec_valid_o, rec_rx_ticks_o, rec_tx_ticks_o, rec_delta_o, rec_orphan_o); end
    n_checks++; if (max_delta_o !== 8'd0 || rx_drop_cnt_o !== 3'd0 || rec_drop_cnt_o !== 3'd0) begin
      n_errors++; $display("FAIL rst_async_stats: got %0d/%0d/%0d exp 0", max_delta_o, rx_drop_cnt_o, rec_drop_cnt_o); end
    @(negedge clk_i);
    rst_ni = 1'b1;
    t3 = m_tick;
    pulse(1, 0, 0, 0);
    pulse(0, 0, 1, 1);
    n_checks++; if (rec_orphan_o !== 1'b0 || rec_rx_ticks_o !== t3 || rec_tx_ticks_o !== 8'(t3 + 8'd1)) begin
      n_errors++; $display("FAIL rst_resume: o%b rx %0d tx %0d exp 0/%0d/%0d", rec_orphan_o, rec_rx_ticks_o, rec_tx_ticks_o, t3, 8'(t3 + 8'd1)); end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < DP + 9; i++) pulse(1, 1, 0, 0);
    n_checks++; if (rx_drop_cnt_o !== 3'd7) begin n_errors++; $display("FAIL sat_rx: got %0d exp 7", rx_drop_cnt_o); end
    for (int i = 0; i < DP + 9; i++) pulse(0, 0, 1, 1);
    n_checks++; if (rec_drop_cnt_o !== 3'd7) begin n_errors++; $display("FAIL sat_rec: got %0d exp 7", rec_drop_cnt_o); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      rx_tvalid_i = ($urandom_range(0, 2) != 0);
      rx_tready_i = ($urandom_range(0, 3) != 0);
      rx_tlast_i  = ($urandom_range(0, 2) == 0);
      tx_tvalid_i = ($urandom_range(0, 2) != 0);
      tx_tready_i = ($urandom_range(0, 3) != 0);
      tx_tlast_i  = ($urandom_range(0, 3) == 0);
      rec_ready_i = ($urandom_range(0, 2) == 0);
      clear_i     = ($urandom_range(0, 199) == 0);
      cycle();
      n_checks++; if (rec_valid_o !== (m_recs.size() != 0)) begin
        n_errors++; $display("FAIL rnd_valid c%0d: got %b exp %b", c, rec_valid_o, m_recs.size() != 0); end
      if (m_recs.size() != 0) begin
        n_checks++; if (rec_rx_ticks_o !== m_recs[0].rx || rec_tx_ticks_o !== m_recs[0].tx ||
                        rec_delta_o !== m_recs[0].delta || rec_orphan_o !== m_recs[0].orphan) begin
          n_errors++; $display("FAIL rnd_rec c%0d: got %0d/%0d/%0d/%b exp %0d/%0d/%0d/%b", c, rec_rx_ticks_o, rec_tx_ticks_o,
                               rec_delta_o, rec_orphan_o, m_recs[0].rx, m_recs[0].tx, m_recs[0].delta, m_recs[0].orphan); end
      end
      n_checks++; if (max_delta_o !== m_max || rx_drop_cnt_o !== 3'(m_rxd) || rec_drop_cnt_o !== 3'(m_recd)) begin
        n_errors++; $display("FAIL rnd_stats c%0d: got %0d/%0d/%0d exp %0d/%0d/%0d", c, max_delta_o, rx_drop_cnt_o,
                             rec_drop_cnt_o, m_max, m_rxd, m_recd); end
    end
    clear_i = 0; rec_ready_i = 0;
  endtask

  initial begin
    rst_ni = 1'b0;
    test_reset();
    test_single_packet();
    test_wrap();
    test_overflow();
    test_back_pressure();
    test_simultaneous();
    test_clear();
    test_reset_midpacket();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pkt_latency_monitor.md
PKT_LATENCY_MONITOR -- requirements
Module: pkt_latency_monitor

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 32: width of the tick counter, timestamps and delta.
REQ-002 SHALL have parameter DEPTH, default 8: entries in each internal FIFO (power of 2, at least 2).
REQ-003 SHALL have parameter DROP_WIDTH, default 16: width of the drop counters.
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_ni, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have ports rx_tvalid_i, rx_tready_i and rx_tlast_i, inputs, 1 bit each: a monitored copy of the MAC receive AXI-Stream handshake.
REQ-007 SHALL have ports tx_tvalid_i, tx_tready_i and tx_tlast_i, inputs, 1 bit each: a monitored copy of the MAC transmit AXI-Stream handshake.
REQ-008 SHALL have port clear_i, input, 1 bit: synchronous flush of the FIFOs and statistics.
REQ-009 SHALL have port rec_valid_o, output, 1 bit: a latency record is available.
REQ-010 SHALL have port rec_ready_i, input, 1 bit: the consumer accepts the record.
REQ-011 SHALL have ports rec_rx_ticks_o, rec_tx_ticks_o and rec_delta_o, outputs, CNT_WIDTH each: the record fields.
REQ-012 SHALL have port rec_orphan_o, output, 1 bit: the record has no rx timestamp.
REQ-013 SHALL have port max_delta_o, output, CNT_WIDTH: the largest non-orphan delta recorded since reset or clear.
REQ-014 SHALL have ports rx_drop_cnt_o and rec_drop_cnt_o, outputs, DROP_WIDTH each: the drop counters.

Function
REQ-015 SHALL keep a free-running tick counter that increments every cycle and wraps from 2^CNT_WIDTH-1 to 0; clear_i does not affect it.
REQ-016 SHALL track first-beat state: set on reset, and on each rx handshake (tvalid&tready) load it with rx_tlast_i.
REQ-017 SHALL push the current tick value into the rx-stamp FIFO on an rx handshake while first-beat state is 1.
REQ-018 SHALL treat a tx handshake with tx_tlast_i=1 as tx-done: pop the rx-stamp head, form a record {rx, tx=current tick, delta}, and push it to the record FIFO.
REQ-019 SHALL compute delta as (tx - rx) modulo 2^CNT_WIDTH, so a wrapped counter still gives the correct latency.
REQ-020 SHALL, on tx-done with the rx-stamp FIFO empty, push an orphan record: rx=0, delta=0, orphan=1.
REQ-021 SHALL give tx-done only the head present before the edge: an rx push in the same cycle into an empty FIFO is not paired, so the record is an orphan and the new stamp is retained.
REQ-022 SHALL, when the rx-stamp FIFO is full, accept an rx push in the same cycle as a tx-done pop; without a pop, drop the stamp and increment rx_drop_cnt_o.
REQ-023 SHALL, when the record FIFO is full, accept a record push in the same cycle as a rec pop; without a pop, drop the record, increment rec_drop_cnt_o, and still pop the rx stamp.
REQ-024 SHALL saturate both drop counters at all-ones.
REQ-025 SHALL present the record FIFO head on the rec_* outputs with zero-latency show-ahead.
REQ-026 SHALL assert rec_valid_o whenever the record FIFO is non-empty and pop it on rec_valid_o & rec_ready_i.
REQ-027 SHALL hold rec_* outputs stable while rec_valid_o=1 and rec_ready_i=0.
REQ-028 SHALL update max_delta_o one cycle after a non-orphan record push, including records later dropped at the record FIFO.
REQ-029 SHALL, on clear_i=1, empty both FIFOs and zero max_delta_o and both drop counters; same-cycle events are discarded and first-beat state is set to 1.
REQ-030 SHALL not constrain the monitored handshakes: the block only observes them and never back-pressures.

Reset
REQ-031 SHALL, while rst_ni=0, asynchronously set: tick counter=0, both FIFOs empty, first-beat state=1, rec_valid_o=0, all rec_* outputs=0, max_delta_o=0, both drop counters=0.
REQ-032 SHALL resume counting on the first clk_i edge after rst_ni is released; a packet in progress at reset is treated as ended.

Verification
REQ-033 SHALL pass single packet: 3-beat rx whose first beat is at tick 10, tx last at tick 50 -> one record, rx=10, tx=50, delta=40, orphan=0, max_delta_o=40.
REQ-034 SHALL pass wrap: CNT_WIDTH=8, rx first at tick 250, tx last at tick 4 -> delta=10.
REQ-035 SHALL pass overflow: DEPTH=4, 6 rx packets with no tx -> rx_drop_cnt_o=2; then 5 tx-done -> 4 records plus 1 orphan.
REQ-036 SHALL pass back-pressure: rec_ready_i=0 while DEPTH+2 tx-done occur -> rec_drop_cnt_o=2 and rec outputs stable; then rec_ready_i=1 -> DEPTH records delivered in order.
REQ-037 SHALL pass simultaneous events: rx first beat and tx-done in the same cycle with the rx-stamp FIFO empty -> orphan record, and the stamp is paired with the next tx-done.
REQ-038 SHALL pass reset and clear: rst_ni low mid-packet -> all outputs 0 immediately; clear_i with 3 records pending -> rec_valid_o=0 next cycle and counters=0.
